// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory request/acknowledge bus
//   imem_req  : fetch request, sequencer to memory
//   imem_addr : fetch address, sequencer to memory
//   imem_ack  : instr_in valid this cycle, memory to sequencer
//   instr_in  : instruction word, memory to sequencer
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] instr_in;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  instr_in
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output instr_in
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RV32I fetch and next-PC sequencer
//   clk, rst          : clock, synchronous active-high reset
//   start             : leave IDLE and begin fetching
//   imem              : instruction-memory handshake (master side)
//   instr/instr_valid : latched instruction, pulse on first EXEC cycle
//   exec_done         : datapath finished; next-PC inputs valid this cycle
//   branch/jump/jalr  : redirect class of the current instruction
//   imm/alu_result    : branch/JAL offset, JALR target sum
//   negative          : compare result deciding a conditional branch
//   pc/pc_plus4       : program counter and its sequential successor
//   taken             : pulse after a non-sequential redirect
//   misaligned        : sticky fetch-target alignment fault
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  pc_sequencer_if.master        imem,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  branch,
  input  logic                  jump,
  input  logic                  jalr,
  input  logic [31:0]           imm,
  input  logic [31:0]           alu_result,
  input  logic                  negative,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic                  taken,
  output logic                  misaligned
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] target;
  logic        nonseq;
  logic        fault;

  assign pc_plus4       = pc + STEP;
  assign imem.imem_addr = pc;
  // Request is a pure decode of the state, so it is stable for the whole
  // FETCH wait and drops on the same edge that reset or ack moves us out.
  assign imem.imem_req  = (state == FETCH);

  // Next-PC selection: jalr > jump > taken branch > sequential.
  always_comb begin
    target = pc_plus4;
    nonseq = 1'b0;
    if (jalr) begin
      target = alu_result & 32'hFFFF_FFFE;
      nonseq = 1'b1;
    end else if (jump) begin
      target = pc + imm;
      nonseq = 1'b1;
    end else if (branch && negative) begin
      target = pc + imm;
      nonseq = 1'b1;
    end
    fault = (target[1:0] != 2'b00);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (imem.imem_ack) state_next = EXEC;
      EXEC:    if (exec_done) state_next = fault ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      taken       <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      taken       <= 1'b0;
      if (state == FETCH && imem.imem_ack) begin
        instr       <= imem.instr_in;
        instr_valid <= 1'b1;
      end
      if (state == EXEC && exec_done) begin
        // A faulting target leaves pc pointing at the offending instruction.
        if (fault) begin
          misaligned <= 1'b1;
        end else begin
          pc    <= target;
          taken <= nonseq;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst1, start, start1;
  logic        exec_done, branch, jump, jalr, negative;
  logic [31:0] imm, alu_result;

  pc_sequencer_if bus0();
  pc_sequencer_if bus1();

  logic [31:0] instr0, pc0, pc_plus4_0;
  logic        instr_valid0, taken0, mis0;
  logic [31:0] instr1, pc1, pc_plus4_1;
  logic        instr_valid1, taken1, mis1;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .imem(bus0),
    .instr(instr0), .instr_valid(instr_valid0), .exec_done(exec_done),
    .branch(branch), .jump(jump), .jalr(jalr), .imm(imm),
    .alu_result(alu_result), .negative(negative), .pc(pc0),
    .pc_plus4(pc_plus4_0), .taken(taken0), .misaligned(mis0)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .imem(bus1),
    .instr(instr1), .instr_valid(instr_valid1), .exec_done(exec_done),
    .branch(branch), .jump(jump), .jalr(jalr), .imm(imm),
    .alu_result(alu_result), .negative(negative), .pc(pc1),
    .pc_plus4(pc_plus4_1), .taken(taken1), .misaligned(mis1)
  );

  typedef struct {
    logic [31:0] setup_pc;
    logic        br, jp, jr, neg;
    logic [31:0] im, alu;
    logic [31:0] exp_pc;
    logic        exp_tk, exp_mis;
  } vec_t;

  vec_t        vecs[9];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cur_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags;
    exec_done = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
    negative = 1'b0; imm = 32'h0; alu_result = 32'h0;
  endtask

  // Next pc, taken and fault from the redirect rules, in plain arithmetic.
  function automatic void ref_next(input logic [31:0] pcv, input logic br, jp, jr, neg,
                                   input logic [31:0] im, alu,
                                   output logic [31:0] npc, output logic tk, output logic mis);
    logic [31:0] t;
    logic        ns;
    if (jr) begin
      t = alu - (alu % 2); ns = 1'b1;
    end else if (jp || (br && neg)) begin
      t = pcv + im; ns = 1'b1;
    end else begin
      t = pcv + 32'd4; ns = 1'b0;
    end
    mis = (t % 4) != 0;
    npc = mis ? pcv : t;
    tk  = mis ? 1'b0 : ns;
  endfunction

  task automatic run_instr(input int waits, input int delay, input logic [31:0] word,
                           input logic br, jp, jr, neg, input logic [31:0] im, alu,
                           input logic [31:0] exp_pc, input logic exp_tk, exp_mis);
    check("fetch_req", bus0.imem_req, 1);
    check("fetch_addr", bus0.imem_addr, cur_pc);
    for (int i = 0; i < waits; i++) begin
      exec_done  = $urandom_range(0, 1);
      jalr       = 1'b1;
      alu_result = $urandom;
      tick;
      check("wait_req", bus0.imem_req, 1);
      check("wait_addr", bus0.imem_addr, cur_pc);
      check("wait_pc", pc0, cur_pc);
    end
    clear_flags();
    bus0.imem_ack = 1'b1;
    bus0.instr_in = word;
    tick;
    bus0.imem_ack = 1'b0;
    check("instr_valid", instr_valid0, 1);
    check("instr", instr0, word);
    check("exec_req", bus0.imem_req, 0);
    for (int i = 0; i < delay; i++) begin
      bus0.imem_ack = 1'b1;
      bus0.instr_in = $urandom;
      tick;
      check("valid_once", instr_valid0, 0);
      check("instr_hold", instr0, word);
      check("exec_pc", pc0, cur_pc);
    end
    bus0.imem_ack = 1'b0;
    branch = br; jump = jp; jalr = jr; negative = neg; imm = im; alu_result = alu;
    exec_done = 1'b1;
    tick;
    clear_flags();
    check("next_pc", pc0, exp_pc);
    check("taken", taken0, exp_tk);
    check("misaligned", mis0, exp_mis);
    check("post_req", bus0.imem_req, !exp_mis);
    if (!exp_mis) begin
      tick;
      check("taken_pulse", taken0, 0);
    end
    cur_pc = exp_pc;
  endtask

  task automatic halt_check;
    start = 1'b1; exec_done = 1'b1; bus0.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("halt_req", bus0.imem_req, 0);
      check("halt_pc", pc0, cur_pc);
      check("halt_mis", mis0, 1);
      check("halt_valid", instr_valid0, 0);
    end
    start = 1'b0; exec_done = 1'b0; bus0.imem_ack = 1'b0;
  endtask

  task automatic reset_start;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("rst_pc", pc0, 32'h0);
    check("rst_req", bus0.imem_req, 0);
    check("rst_mis", mis0, 0);
    check("rst_instr", instr0, 0);
    check("rst_taken", taken0, 0);
    check("rst_valid", instr_valid0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    cur_pc = 32'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] npc, im, alu;
    logic        tk, mis, br, jp, jr, neg;

    vecs[0] = '{32'h10,  1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0,   32'h08,  1, 0};
    vecs[1] = '{32'h10,  1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,   32'h14,  0, 0};
    vecs[2] = '{32'h20,  0, 1, 1, 0, 32'h40,        32'h101, 32'h100, 1, 0};
    vecs[3] = '{32'h20,  0, 1, 0, 0, 32'h2,         32'h0,   32'h20,  0, 1};
    vecs[4] = '{32'h40,  0, 0, 0, 1, 32'h80,        32'h0,   32'h44,  0, 0};
    vecs[5] = '{32'h80,  0, 1, 0, 0, 32'hFFFF_FF80, 32'h0,   32'h00,  1, 0};
    vecs[6] = '{32'h30,  0, 0, 1, 0, 32'h0,         32'h102, 32'h30,  0, 1};
    vecs[7] = '{32'h100, 1, 1, 0, 0, 32'h10,        32'h0,   32'h110, 1, 0};
    vecs[8] = '{32'hFFFF_FFFC, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 0};

    rst = 1'b1; rst1 = 1'b1; start = 1'b0; start1 = 1'b0;
    clear_flags();
    bus0.imem_ack = 1'b0; bus0.instr_in = 32'h0;
    bus1.imem_ack = 1'b0; bus1.instr_in = 32'h0;
    tick; tick;
    rst = 1'b0;
    tick;
    check("idle_req", bus0.imem_req, 0);
    check("idle_pc", pc0, 32'h0);
    check("idle_pc4", pc_plus4_0, 32'h4);
    start = 1'b1;
    tick;
    start = 1'b0;
    cur_pc = 32'h0;

    // First instruction: two wait cycles, addi x0 nop, sequential advance.
    run_instr(2, 1, 32'h0000_0013, 0, 0, 0, 0, 32'h0, 32'h0, 32'h4, 0, 0);

    foreach (vecs[k]) begin
      run_instr($urandom_range(0, 2), 0, $urandom, 0, 0, 1, 0, 32'h0,
                vecs[k].setup_pc, vecs[k].setup_pc, 1, 0);
      check("setup_pc4", pc_plus4_0, vecs[k].setup_pc + 32'd4);
      run_instr($urandom_range(0, 2), $urandom_range(0, 1), $urandom,
                vecs[k].br, vecs[k].jp, vecs[k].jr, vecs[k].neg, vecs[k].im, vecs[k].alu,
                vecs[k].exp_pc, vecs[k].exp_tk, vecs[k].exp_mis);
      if (vecs[k].exp_mis) begin
        halt_check();
        reset_start();
      end
    end

    for (int n = 0; n < 200; n++) begin
      br = $urandom_range(0, 1); jp = $urandom_range(0, 3) == 0;
      jr = $urandom_range(0, 3) == 0; neg = $urandom_range(0, 1);
      im = $urandom;
      if ($urandom_range(0, 15) != 0) im[1:0] = 2'b00;
      alu = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
      ref_next(cur_pc, br, jp, jr, neg, im, alu, npc, tk, mis);
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                br, jp, jr, neg, im, alu, npc, tk, mis);
      if (mis) begin
        halt_check();
        reset_start();
      end
    end

    // Reset-vector wrap and reset in the middle of a fetch handshake.
    rst1 = 1'b0;
    tick;
    check("r1_pc", pc1, 32'hFFFF_FFFC);
    check("r1_req", bus1.imem_req, 0);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    check("r1_fetch_req", bus1.imem_req, 1);
    check("r1_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_ack = 1'b1; bus1.instr_in = 32'h0000_0013;
    tick;
    bus1.imem_ack = 1'b0;
    check("r1_valid", instr_valid1, 1);
    exec_done = 1'b1;
    tick;
    exec_done = 1'b0;
    check("r1_wrap_pc", pc1, 32'h0);
    check("r1_taken", taken1, 0);
    check("r1_refetch", bus1.imem_req, 1);
    rst1 = 1'b1;
    tick;
    rst1 = 1'b0;
    check("r1_mid_req", bus1.imem_req, 0);
    check("r1_mid_pc", pc1, 32'hFFFF_FFFC);
    check("r1_mid_instr", instr1, 32'h0);
    tick;
    check("r1_idle_req", bus1.imem_req, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
